// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game controller.
//   game_state_e : top-level game flow encoding (value is visible on state_o)
//   GridW/GridHDef : playfield geometry, CoordW : width of a cell coordinate
//   BcdW : width of a 4-digit BCD counter
package snake_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSpawn = 2'd1,
    StPlay  = 2'd2,
    StOver  = 2'd3
  } game_state_e;

  localparam int unsigned GridW    = 32;
  localparam int unsigned GridHDef = 24;
  localparam int unsigned CoordW   = 5;
  localparam int unsigned BcdW     = 16;

endpackage

// File: rtl/snake_game_ctrl_bcd_counter4.sv
// Four-digit saturating BCD counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear (wins over inc_i)
//   inc_i      : add one, per-digit decimal carry, holds at 9999
//   q_o        : packed BCD value, digit 0 in [3:0]
module bcd_counter4
  import snake_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [BcdW-1:0] q_o
);

  logic [BcdW-1:0] cnt_q, cnt_d;
  logic            carry;

  always_comb begin
    cnt_d = cnt_q;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (cnt_q[4*i +: 4] == 4'd9) begin
          cnt_d[4*i +: 4] = 4'd0;
        end else begin
          cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (!inc_i || cnt_q == 16'h9999) cnt_d = cnt_q;
    if (clr_i) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: edge-detects the collision/start levels, runs the
// IDLE/SPAWN/PLAY/GAME_OVER flow, places apples with bounded retry, keeps BCD
// score and elapsed seconds, and generates a shrinking-period move tick.
//   start_i/cllsn_i/apple_cllsn_i : level inputs, one event per rising level
//   rand_x_i/rand_y_i, occupied_i : apple candidate source and occupancy answer
//   rand_ld_o, query_vld_o, query_x_o/query_y_o : placement handshake
//   apple_x_o/apple_y_o : committed apple, move_tick_o : snake step pulse
//   state_o, score_bcd_o, time_bcd_o : status for display
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned SecCycles = 100_000_000,
  parameter int unsigned StepInit  = 10_000_000,
  parameter int unsigned StepMin   = 2_500_000,
  parameter int unsigned StepDec   = 250_000,
  parameter int unsigned GridH     = GridHDef,
  parameter int unsigned MaxRetry  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              cllsn_i,
  input  logic              apple_cllsn_i,
  input  logic [CoordW-1:0] rand_x_i,
  input  logic [CoordW-1:0] rand_y_i,
  input  logic              occupied_i,
  output logic              rand_ld_o,
  output logic              query_vld_o,
  output logic [CoordW-1:0] query_x_o,
  output logic [CoordW-1:0] query_y_o,
  output logic [CoordW-1:0] apple_x_o,
  output logic [CoordW-1:0] apple_y_o,
  output logic              move_tick_o,
  output logic [1:0]        state_o,
  output logic [BcdW-1:0]   score_bcd_o,
  output logic [BcdW-1:0]   time_bcd_o
);

  localparam logic [CoordW-1:0] GridHY = CoordW'(GridH);

  game_state_e       state_q;
  logic [1:0]        phase_q;
  logic              start_q, cllsn_q, apple_q;
  logic              rand_ld_q, query_vld_q, move_tick_q;
  logic [CoordW-1:0] query_x_q, query_y_q, apple_x_q, apple_y_q;
  int unsigned       retry_q, sec_cnt_q, step_cnt_q, period_q;

  logic        start_ev, cllsn_ev, apple_ev;
  logic        time_run, sec_wrap, step_wrap, cand_bad;
  logic        cnt_clr, score_inc;
  int unsigned period_next;

  assign start_ev  = start_i & ~start_q;
  assign cllsn_ev  = cllsn_i & ~cllsn_q;
  assign apple_ev  = apple_cllsn_i & ~apple_q;

  assign time_run  = (state_q == StSpawn) || (state_q == StPlay);
  assign sec_wrap  = time_run && (sec_cnt_q == SecCycles - 1);
  assign step_wrap = (state_q == StPlay) && (step_cnt_q == period_q - 1);
  assign cand_bad  = occupied_i || (query_y_q >= GridHY);
  assign cnt_clr   = start_ev && ((state_q == StIdle) || (state_q == StOver));
  // Collision wins: an apple reached in the same cycle as a crash is not scored.
  assign score_inc = (state_q == StPlay) && apple_ev && !cllsn_ev;

  // Guarded subtraction so the period never underflows below the floor.
  assign period_next = (period_q >= StepMin + StepDec) ? period_q - StepDec : StepMin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      phase_q     <= 2'd0;
      start_q     <= 1'b0;
      cllsn_q     <= 1'b0;
      apple_q     <= 1'b0;
      rand_ld_q   <= 1'b0;
      query_vld_q <= 1'b0;
      move_tick_q <= 1'b0;
      query_x_q   <= '0;
      query_y_q   <= '0;
      apple_x_q   <= '0;
      apple_y_q   <= '0;
      retry_q     <= '0;
      sec_cnt_q   <= '0;
      step_cnt_q  <= '0;
      period_q    <= StepInit;
    end else begin
      start_q     <= start_i;
      cllsn_q     <= cllsn_i;
      apple_q     <= apple_cllsn_i;
      rand_ld_q   <= 1'b0;
      query_vld_q <= 1'b0;
      move_tick_q <= 1'b0;
      if (time_run) sec_cnt_q <= sec_wrap ? '0 : sec_cnt_q + 1;
      case (state_q)
        StIdle, StOver: begin
          if (start_ev) begin
            retry_q    <= '0;
            period_q   <= StepInit;
            sec_cnt_q  <= '0;
            step_cnt_q <= '0;
            phase_q    <= 2'd0;
            rand_ld_q  <= 1'b1;
            state_q    <= StSpawn;
          end
        end
        StSpawn: begin
          unique case (phase_q)
            2'd0: begin
              query_x_q   <= rand_x_i;
              query_y_q   <= rand_y_i;
              query_vld_q <= 1'b1;
              phase_q     <= 2'd1;
            end
            2'd1: phase_q <= 2'd2;
            default: begin
              if (cand_bad && (retry_q < MaxRetry)) begin
                retry_q   <= retry_q + 1;
                phase_q   <= 2'd0;
                rand_ld_q <= 1'b1;
              end else begin
                // Forced accept may carry an off-grid row; fold it to row 0.
                apple_x_q <= query_x_q;
                apple_y_q <= (query_y_q >= GridHY) ? '0 : query_y_q;
                retry_q   <= '0;
                state_q   <= StPlay;
              end
            end
          endcase
        end
        StPlay: begin
          if (cllsn_ev) begin
            state_q <= StOver;
          end else if (apple_ev) begin
            period_q   <= period_next;
            step_cnt_q <= '0;
            phase_q    <= 2'd0;
            rand_ld_q  <= 1'b1;
            state_q    <= StSpawn;
          end else begin
            step_cnt_q  <= step_wrap ? '0 : step_cnt_q + 1;
            move_tick_q <= step_wrap;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  bcd_counter4 u_score (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(cnt_clr),
    .inc_i(score_inc),
    .q_o  (score_bcd_o)
  );

  bcd_counter4 u_time (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(cnt_clr),
    .inc_i(sec_wrap),
    .q_o  (time_bcd_o)
  );

  assign rand_ld_o   = rand_ld_q;
  assign query_vld_o = query_vld_q;
  assign query_x_o   = query_x_q;
  assign query_y_o   = query_y_q;
  assign apple_x_o   = apple_x_q;
  assign apple_y_o   = apple_y_q;
  assign move_tick_o = move_tick_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed testbench for snake_game_ctrl with small timing parameters.
module tb_snake_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_i, cllsn_i, apple_cllsn_i, occupied_i;
  logic [4:0]  rand_x_i, rand_y_i;
  logic        rand_ld_o, query_vld_o, move_tick_o;
  logic [4:0]  query_x_o, query_y_o, apple_x_o, apple_y_o;
  logic [1:0]  state_o;
  logic [15:0] score_bcd_o, time_bcd_o;
  logic        u_clr, u_inc;
  logic [15:0] u_q;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  snake_game_ctrl #(
    .SecCycles(20),
    .StepInit (10),
    .StepMin  (4),
    .StepDec  (2),
    .GridH    (24),
    .MaxRetry (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .cllsn_i      (cllsn_i),
    .apple_cllsn_i(apple_cllsn_i),
    .rand_x_i     (rand_x_i),
    .rand_y_i     (rand_y_i),
    .occupied_i   (occupied_i),
    .rand_ld_o    (rand_ld_o),
    .query_vld_o  (query_vld_o),
    .query_x_o    (query_x_o),
    .query_y_o    (query_y_o),
    .apple_x_o    (apple_x_o),
    .apple_y_o    (apple_y_o),
    .move_tick_o  (move_tick_o),
    .state_o      (state_o),
    .score_bcd_o  (score_bcd_o),
    .time_bcd_o   (time_bcd_o)
  );

  bcd_counter4 u_bcd (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(u_clr),
    .inc_i(u_inc),
    .q_o  (u_q)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_state"}, 32'(state_o), 32'd0);
    check_val({tag, "_score"}, 32'(score_bcd_o), 32'd0);
    check_val({tag, "_time"}, 32'(time_bcd_o), 32'd0);
    check_val({tag, "_apple"}, 32'({apple_x_o, apple_y_o}), 32'd0);
    check_val({tag, "_query"}, 32'({query_x_o, query_y_o}), 32'd0);
    check_val({tag, "_pulses"}, 32'({rand_ld_o, query_vld_o, move_tick_o}), 32'd0);
  endtask

  // Hold apple_cllsn for 'hold' cycles, counting PRNG advance pulses.
  task automatic do_apple(input int hold, output int n_ld);
    n_ld = 0;
    apple_cllsn_i = 1'b1;
    repeat (hold) begin
      step();
      if (rand_ld_o) n_ld++;
    end
    apple_cllsn_i = 1'b0;
    step();
  endtask

  // Cycles between two consecutive move ticks; 0 if no tick in time.
  task automatic measure_period(output int p);
    int k;
    p = 0;
    k = 0;
    while (!move_tick_o && k < 60) begin
      step();
      k++;
    end
    if (move_tick_o) begin
      k = 0;
      do begin
        step();
        k++;
      end while (!move_tick_o && k < 60);
      if (move_tick_o) p = k;
    end
  endtask

  task automatic wait_play(output int n_ld, output int ok);
    n_ld = 0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (rand_ld_o) n_ld++;
      if (state_o == 2'd2) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    int n, ok, p, ticks, bad;
    logic [15:0] t_frz;
    start_i = 0; cllsn_i = 0; apple_cllsn_i = 0; occupied_i = 0;
    rand_x_i = 5'd5; rand_y_i = 5'd7; u_clr = 0; u_inc = 0;

    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // First game: single clean placement, cycle-accurate handshake.
    start_i = 1'b1;
    step();
    check_val("c0_state", 32'(state_o), 32'd1);
    check_val("c0_rand_ld", 32'(rand_ld_o), 32'd1);
    check_val("c0_qvld", 32'(query_vld_o), 32'd0);
    step();
    start_i = 1'b0;
    check_val("c1_rand_ld", 32'(rand_ld_o), 32'd0);
    check_val("c1_qvld", 32'(query_vld_o), 32'd1);
    check_val("c1_query", 32'({query_x_o, query_y_o}), 32'({5'd5, 5'd7}));
    step();
    check_val("c2_qvld", 32'(query_vld_o), 32'd0);
    check_val("c2_state", 32'(state_o), 32'd1);
    step();
    check_val("c3_state", 32'(state_o), 32'd2);
    check_val("c3_apple", 32'({apple_x_o, apple_y_o}), 32'({5'd5, 5'd7}));

    // Held apple level scores once and respawns once.
    do_apple(50, n);
    check_val("held_rand_ld", 32'(n), 32'd1);
    check_val("held_score", 32'(score_bcd_o), 32'h0001);
    check_val("held_state", 32'(state_o), 32'd2);
    measure_period(p);
    check_val("period_1", 32'(p), 32'd8);

    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check_val("start_in_play", 32'(state_o), 32'd2);

    do_apple(6, n);
    do_apple(6, n);
    check_val("score_3", 32'(score_bcd_o), 32'h0003);
    check_val("play_before_rst", 32'(state_o), 32'd2);

    // Asynchronous reset mid-cycle.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    step();
    rst_n = 1'b1;

    // Placement retries exhausted, off-grid row folded to 0.
    rand_x_i = 5'd9; rand_y_i = 5'd30; occupied_i = 1'b1;
    start_i = 1'b1;
    wait_play(n, ok);
    start_i = 1'b0;
    check_val("retry_play", 32'(ok), 32'd1);
    check_val("retry_rand_ld", 32'(n), 32'd3);
    check_val("retry_apple", 32'({apple_x_o, apple_y_o}), 32'({5'd9, 5'd0}));

    rand_x_i = 5'd5; rand_y_i = 5'd7; occupied_i = 1'b0;
    repeat (4) do_apple(6, n);
    check_val("score_4", 32'(score_bcd_o), 32'h0004);
    measure_period(p);
    check_val("period_4", 32'(p), 32'd4);
    do_apple(6, n);
    check_val("score_5", 32'(score_bcd_o), 32'h0005);
    measure_period(p);
    check_val("period_5", 32'(p), 32'd4);

    // Collision and apple in the same cycle.
    cllsn_i = 1'b1; apple_cllsn_i = 1'b1;
    step();
    check_val("both_state", 32'(state_o), 32'd3);
    check_val("both_score", 32'(score_bcd_o), 32'h0005);
    t_frz = time_bcd_o;
    n = 0;
    repeat (10) begin
      step();
      if (rand_ld_o) n++;
    end
    check_val("both_rand_ld", 32'(n), 32'd0);
    cllsn_i = 1'b0; apple_cllsn_i = 1'b0;
    step();
    apple_cllsn_i = 1'b1;
    repeat (25) step();
    apple_cllsn_i = 1'b0;
    check_val("over_score", 32'(score_bcd_o), 32'h0005);
    check_val("over_state", 32'(state_o), 32'd3);
    check_val("over_time", 32'(time_bcd_o), 32'(t_frz));
    check_val("over_apple", 32'({apple_x_o, apple_y_o}), 32'({5'd5, 5'd7}));

    // Restart from GAME_OVER; 200 counted cycles of time and tick cadence 10.
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check_val("rs_state", 32'(state_o), 32'd1);
    check_val("rs_score", 32'(score_bcd_o), 32'h0000);
    check_val("rs_time", 32'(time_bcd_o), 32'h0000);
    step();
    step();
    step();
    check_val("rs_play", 32'(state_o), 32'd2);
    ticks = 0;
    bad = 0;
    for (int i = 1; i <= 197; i++) begin
      step();
      if (move_tick_o) begin
        ticks++;
        if (i % 10 != 0) bad++;
      end
      if (i == 196) check_val("time_199", 32'(time_bcd_o), 32'h0009);
    end
    check_val("time_200", 32'(time_bcd_o), 32'h0010);
    check_val("tick_count", 32'(ticks), 32'd19);
    check_val("tick_phase", 32'(bad), 32'd0);

    // BCD counter carry chain and saturation.
    u_clr = 1'b1;
    step();
    u_clr = 1'b0;
    check_val("bcd_clr0", 32'(u_q), 32'h0000);
    u_inc = 1'b1;
    repeat (10) step();
    check_val("bcd_10", 32'(u_q), 32'h0010);
    repeat (89) step();
    check_val("bcd_99", 32'(u_q), 32'h0099);
    repeat (9900) step();
    check_val("bcd_9999", 32'(u_q), 32'h9999);
    repeat (3) step();
    check_val("bcd_sat", 32'(u_q), 32'h9999);
    u_inc = 1'b0;
    u_clr = 1'b1;
    step();
    u_clr = 1'b0;
    check_val("bcd_clr", 32'(u_q), 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
